// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter that drives the select of a 4:1 mux.
// A granted source keeps the mux for BURST_LEN accepted transfers. After that
// the rotation pointer moves past it and the remaining requesters are searched
// in the same clock edge, so there is no idle cycle between grants.
// A source that drops its request without a transfer gives up the grant.
// Optional feature: define MUX_SEL_ARBITER_LOCK_EN to add the `lock` input.
// While lock is high, the current grant is kept past the end of its burst.
module mux_sel_arbiter #(
    parameter int BURST_LEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
`ifdef MUX_SEL_ARBITER_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the last beat of a burst.
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;

    logic       out_valid_s;
    logic       xfer_s;
    logic       lock_s;
    logic [1:0] ptr_next_s;
    logic [3:0] others_s;
    logic [2:0] pick_idle_s;
    logic [2:0] pick_rot_s;

    // Search r starting at bit `start` and wrapping modulo 4.
    // Returns {found, index}. The loop runs from the farthest offset down
    // to offset 0, so the nearest set bit is the one written last and wins.
    function automatic logic [2:0] pick_first(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Turn a 2-bit select code into the matching one-hot grant vector.
    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

`ifdef MUX_SEL_ARBITER_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // State register: holds every piece of arbiter state; reset clears it all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Helper terms: the rotated pointer, the other requesters, and both searches.
    always_comb begin
        ptr_next_s  = sel_q + 2'd1;
        others_s    = req & ~onehot(sel_q);
        pick_idle_s = pick_first(req, ptr_q);
        pick_rot_s  = pick_first(others_s, ptr_next_s);
        xfer_s      = out_valid_s && out_ready;
    end

    // Next-state logic: arbitration, beat counting, rotation and release.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                cnt_d   = 4'd0;
                if (pick_idle_s[2]) begin
                    sel_d   = pick_idle_s[1:0];
                    grant_d = onehot(pick_idle_s[1:0]);
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (xfer_s) begin
                    if (cnt_q >= LAST_BEAT) begin
                        cnt_d = 4'd0;
                        if (lock_s) begin
                            // Locked: start another burst on the same source.
                            state_d = GRANT;
                        end else begin
                            ptr_d = ptr_next_s;
                            if (pick_rot_s[2]) begin
                                // Hand over in the same edge, with no idle cycle.
                                sel_d   = pick_rot_s[1:0];
                                grant_d = onehot(pick_rot_s[1:0]);
                                state_d = GRANT;
                            end else begin
                                // No other requester: re-arbitrate from IDLE.
                                // This costs one idle cycle.
                                grant_d = 4'b0000;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (!req[sel_q]) begin
                    // The granted source withdrew: release the grant and rotate past it.
                    ptr_d   = ptr_next_s;
                    cnt_d   = 4'd0;
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end else begin
                    // Stalled by the consumer: hold everything unchanged.
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: out_valid follows the live request of the granted source.
    always_comb begin
        out_valid_s = 1'b0;
        if (state_q == GRANT) begin
            out_valid_s = req[sel_q];
        end else begin
            out_valid_s = 1'b0;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = out_valid_s;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Testbench for mux_sel_arbiter.
// Instance d1 uses BURST_LEN=1 and instance d2 uses BURST_LEN=2.
// Each test pushes its expected per-cycle outputs into a scoreboard queue.
// It then pops one entry per cycle and compares it with the DUT outputs.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req1, req2;
    logic       rdy1, rdy2;
    logic       lock1, lock2;
    logic [1:0] sel1, sel2;
    logic [3:0] grant1, grant2;
    logic       ov1, ov2;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       ov;
    } exp_t;

    exp_t sb[$];

    mux_sel_arbiter #(.BURST_LEN(1)) d1 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1),
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock(lock1),
`endif
        .sel(sel1), .grant(grant1), .out_valid(ov1)
    );

    mux_sel_arbiter #(.BURST_LEN(2)) d2 (
        .clk(clk), .rst(rst), .req(req2), .out_ready(rdy2),
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock(lock2),
`endif
        .sel(sel2), .grant(grant2), .out_valid(ov2)
    );

    function automatic exp_t mk(input logic [1:0] s, input logic [3:0] g, input logic v);
        exp_t e;
        e.sel = s;
        e.grant = g;
        e.ov = v;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req1 = 4'b0000; req2 = 4'b0000;
        rdy1 = 1'b0; rdy2 = 1'b0;
        lock1 = 1'b0; lock2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (sel1 !== 2'd0 || grant1 !== 4'b0000 || ov1 !== 1'b0)
            $display("FAIL reset_d1: sel=%0d grant=%b out_valid=%b expected 0/0000/0", sel1, grant1, ov1);
        else passed++;
        checks++;
        if (sel2 !== 2'd0 || grant2 !== 4'b0000 || ov2 !== 1'b0)
            $display("FAIL reset_d2: sel=%0d grant=%b out_valid=%b expected 0/0000/0", sel2, grant2, ov2);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (grant1 !== 4'b0000 || ov1 !== 1'b0)
            $display("FAIL reset_idle: grant=%b out_valid=%b expected 0000/0", grant1, ov1);
        else passed++;
    endtask

    task automatic test_sole();
        exp_t e;
        do_reset();
        req1 = 4'b0001; rdy1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) sb.push_back(mk(2'd0, 4'b0001, 1'b1));
            else            sb.push_back(mk(2'd0, 4'b0000, 1'b0));
        end
        while (sb.size() > 0) begin
            @(negedge clk); #2;
            e = sb.pop_front();
            checks++;
            if (grant1 !== e.grant || ov1 !== e.ov || (e.ov && sel1 !== e.sel))
                $display("FAIL sole: sel=%0d grant=%b out_valid=%b expected sel=%0d grant=%b out_valid=%b",
                         sel1, grant1, ov1, e.sel, e.grant, e.ov);
            else passed++;
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req1 = 4'b1111; rdy1 = 1'b1;
        for (int k = 0; k < 5; k++) sb.push_back(mk(seq[k], 4'b0001 << seq[k], 1'b1));
        while (sb.size() > 0) begin
            @(negedge clk); #2;
            e = sb.pop_front();
            checks++;
            if (sel1 !== e.sel || grant1 !== e.grant || ov1 !== e.ov)
                $display("FAIL rotate: sel=%0d grant=%b out_valid=%b expected sel=%0d grant=%b out_valid=%b",
                         sel1, grant1, ov1, e.sel, e.grant, e.ov);
            else passed++;
        end
    endtask

    task automatic test_burst_stall();
        exp_t e;
        logic       rdy_tbl [6];
        logic [1:0] sel_tbl [6];
        rdy_tbl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        sel_tbl = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
        do_reset();
        req2 = 4'b0110; rdy2 = 1'b1;
        for (int k = 0; k < 6; k++) sb.push_back(mk(sel_tbl[k], 4'b0001 << sel_tbl[k], 1'b1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rdy2 = rdy_tbl[k];
            #2;
            e = sb.pop_front();
            checks++;
            if (sel2 !== e.sel || grant2 !== e.grant || ov2 !== e.ov)
                $display("FAIL burst_stall[%0d]: sel=%0d grant=%b out_valid=%b expected sel=%0d grant=%b out_valid=%b",
                         k, sel2, grant2, ov2, e.sel, e.grant, e.ov);
            else passed++;
        end
    endtask

    task automatic test_release_wrap();
        do_reset();
        req1 = 4'b1000; rdy1 = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (sel1 !== 2'd3 || grant1 !== 4'b1000 || ov1 !== 1'b1)
            $display("FAIL release_grant3: sel=%0d grant=%b out_valid=%b expected 3/1000/1", sel1, grant1, ov1);
        else passed++;
        req1 = 4'b0000;
        @(negedge clk); #2;
        checks++;
        if (grant1 !== 4'b0000 || ov1 !== 1'b0)
            $display("FAIL release_idle: grant=%b out_valid=%b expected 0000/0", grant1, ov1);
        else passed++;
        req1 = 4'b1001;
        @(negedge clk); #2;
        checks++;
        if (sel1 !== 2'd0 || grant1 !== 4'b0001)
            $display("FAIL release_wrap: sel=%0d grant=%b expected 0/0001", sel1, grant1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req2 = 4'b0100; rdy2 = 1'b1;
        @(negedge clk);
        @(negedge clk); #2;
        checks++;
        if (sel2 !== 2'd2 || grant2 !== 4'b0100 || ov2 !== 1'b1)
            $display("FAIL reset_mid_pre: sel=%0d grant=%b out_valid=%b expected 2/0100/1", sel2, grant2, ov2);
        else passed++;
        rdy2 = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (sel2 !== 2'd0 || grant2 !== 4'b0000 || ov2 !== 1'b0)
            $display("FAIL reset_mid_async: sel=%0d grant=%b out_valid=%b expected 0/0000/0", sel2, grant2, ov2);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        req2 = 4'b1100; rdy2 = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (sel2 !== 2'd2 || grant2 !== 4'b0100)
            $display("FAIL reset_mid_regrant: sel=%0d grant=%b expected 2/0100", sel2, grant2);
        else passed++;
    endtask

`ifdef MUX_SEL_ARBITER_LOCK_EN
    task automatic test_lock();
        exp_t e;
        do_reset();
        req1 = 4'b0011; rdy1 = 1'b1; lock1 = 1'b1;
        for (int k = 0; k < 5; k++) sb.push_back(mk(2'd0, 4'b0001, 1'b1));
        sb.push_back(mk(2'd1, 4'b0010, 1'b1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #2;
            e = sb.pop_front();
            checks++;
            if (sel1 !== e.sel || grant1 !== e.grant || ov1 !== e.ov)
                $display("FAIL lock[%0d]: sel=%0d grant=%b expected sel=%0d grant=%b", k, sel1, grant1, e.sel, e.grant);
            else passed++;
            if (k == 4) lock1 = 1'b0;
        end
        lock1 = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        req1 = 4'b0000; req2 = 4'b0000;
        rdy1 = 1'b0; rdy2 = 1'b0;
        lock1 = 1'b0; lock2 = 1'b0;
        test_reset();
        test_sole();
        test_rotate();
        test_burst_stall();
        test_release_wrap();
        test_reset_mid();
`ifdef MUX_SEL_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
